// File: rtl/apb2apb_pkg.sv
// Shared types, defaults and helpers for the user-to-APB3 bridge and its memory slave.
package apb2apb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    FULLWORD = 2'b00,
    HALFWORD = 2'b01,
    BYTE     = 2'b10,
    RESERVED = 2'b11
  } dsel_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Addresses are in units of the access size, so the legal range scales with it.
  function automatic int size_limit(dsel_t size, int depth);
    case (size)
      FULLWORD: return depth;
      HALFWORD: return 2 * depth;
      BYTE:     return 4 * depth;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [3:0] size_strb(dsel_t size, logic [1:0] lo);
    case (size)
      FULLWORD: return 4'hF;
      HALFWORD: return lo[0] ? 4'hC : 4'h3;
      BYTE:     return 4'b0001 << lo;
      default:  return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/apb2apb_bridge_if.sv
// User-side transfer request/response bundle of the bridge.
interface apb2apb_bridge_if
  import apb2apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  trnsfr;
  logic                  wr;
  logic [1:0]            dsel;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  slverr;
  logic                  done;

  modport master (output trnsfr, wr, dsel, address, data_in,
                  input  data_out, slverr, done);
  modport slave  (input  trnsfr, wr, dsel, address, data_in,
                  output data_out, slverr, done);
endinterface

// File: rtl/apb2apb_slave_mem.sv
// APB3 slave over a word memory: one wait state, size-scaled range check, byte lanes.
module apb2apb_slave_mem
  import apb2apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [1:0]            psize,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  wait_q;
  dsel_t                 size;
  logic [ADDR_WIDTH-1:0] limit;
  logic                  err;
  logic [IW-1:0]         widx;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] shifted;

  assign size  = dsel_t'(psize);
  assign limit = ADDR_WIDTH'(size_limit(size, MEM_DEPTH));
  assign err   = (size == RESERVED) || (paddr >= limit);

  always_comb begin
    widx      = paddr[IW-1:0];
    lane      = 2'd0;
    wdata_rep = pwdata;
    case (size)
      HALFWORD: begin
        widx      = paddr[IW:1];
        lane      = {paddr[0], 1'b0};
        wdata_rep = {2{pwdata[15:0]}};
      end
      BYTE: begin
        widx      = paddr[IW+1:2];
        lane      = paddr[1:0];
        wdata_rep = {4{pwdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem[widx] >> {lane, 3'b000};
    prdata  = '0;
    if (!err) begin
      case (size)
        HALFWORD: prdata = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
        BYTE:     prdata = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
        default:  prdata = shifted;
      endcase
    end
  end

  // Toggles through the access phase: low on the first ACCESS cycle, high on the second.
  always_ff @(posedge clk) begin
    if (rst)                 wait_q <= 1'b0;
    else if (psel && penable) wait_q <= ~wait_q;
    else                     wait_q <= 1'b0;
  end

  assign pready  = psel && penable && wait_q;
  assign pslverr = pready && err;

  // Contents are never reset; a reset on the completion edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && pready && pwrite && !err) begin
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

endmodule

// File: rtl/apb2apb_bridge.sv
// User transfer request to APB3 master, driving an internal memory-backed APB slave.
module apb2apb_bridge
  import apb2apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  apb2apb_bridge_if.slave  bus
);
  logic [1:0]            state;
  logic                  psel, penable, pwrite;
  logic [1:0]            psize;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [3:0]            pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready, pslverr;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  slverr_q, done_q;
  logic                  take;

  // Request is captured when leaving IDLE or when a completion chains straight into the next.
  assign take = bus.trnsfr &&
                ((state == ST_IDLE) || (state == ST_ACCESS && pready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      psize      <= 2'b00;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= 4'h0;
      data_out_q <= '0;
      slverr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      slverr_q <= 1'b0;
      if (take) begin
        paddr  <= bus.address;
        pwrite <= bus.wr;
        psize  <= bus.dsel;
        pwdata <= bus.data_in;
        pstrb  <= size_strb(dsel_t'(bus.dsel), bus.address[1:0]);
      end
      case (state)
        ST_IDLE: if (bus.trnsfr) begin
          state <= ST_SETUP;
          psel  <= 1'b1;
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: if (pready) begin
          done_q   <= 1'b1;
          slverr_q <= pslverr;
          if (!pwrite) data_out_q <= prdata;
          penable  <= 1'b0;
          if (bus.trnsfr) state <= ST_SETUP;
          else begin
            state <= ST_IDLE;
            psel  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.slverr   = slverr_q;
  assign bus.done     = done_q;

  apb2apb_slave_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_slave (
    .clk     (clk),
    .rst     (rst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .psize   (psize),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

endmodule

// File: tb/tb_apb2apb_bridge.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_apb2apb_bridge;
  import apb2apb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb2apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();
  apb2apb_bridge dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          nvec = 0;
  int          errs = 0;
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bif.done === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.due);
        chk("slverr", {31'b0, bif.slverr}, {31'b0, mon_e.err});
        chk(mon_e.wr ? "data_out_hold" : "read_data", bif.data_out, mon_e.data);
      end
    end
  end

  // Drives one request at the current negedge; it is latched at the next posedge.
  task automatic issue(input logic w, input logic [1:0] ds, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input logic er);
    exp_t e;
    bif.trnsfr  = 1'b1;
    bif.wr      = w;
    bif.dsel    = ds;
    bif.address = a;
    bif.data_in = d;
    if (!w) last_rd = er ? 32'h0 : rd;
    e.wr   = w;
    e.data = last_rd;
    e.err  = er;
    e.due  = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic finish_xfer();
    @(negedge clk) bif.trnsfr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic single(input logic w, input logic [1:0] ds, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input logic er);
    issue(w, ds, a, d, rd, er);
    finish_xfer();
  endtask

  initial begin
    logic [31:0] w;
    bif.trnsfr = 1'b0; bif.wr = 1'b0; bif.dsel = 2'b00;
    bif.address = '0; bif.data_in = '0;

    repeat (5) @(negedge clk);
    chk("rst_psel",     {31'b0, dut.psel},    32'h0);
    chk("rst_penable",  {31'b0, dut.penable}, 32'h0);
    chk("rst_data_out", bif.data_out,         32'h0);
    chk("rst_slverr",   {31'b0, bif.slverr},  32'h0);
    chk("rst_done",     {31'b0, bif.done},    32'h0);
    rst = 1'b0;
    @(negedge clk);

    single(1'b1, 2'b00, 32'h000, 32'h11223344, 32'h0, 1'b0);
    single(1'b1, 2'b00, 32'h0FF, 32'h55667788, 32'h0, 1'b0);

    for (int i = 0; i < 10; i++)
      single(1'b1, 2'b00, 32'hF0 + i, 32'h000A3210 + i, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      single(1'b0, 2'b00, 32'hF0 + i, 32'h0, 32'h000A3210 + i, 1'b0);

    single(1'b1, 2'b01, 32'h12, 32'h510FCB29, 32'h0, 1'b0);
    single(1'b1, 2'b01, 32'h13, 32'h510FCB2A, 32'h0, 1'b0);
    single(1'b0, 2'b01, 32'h13, 32'h0, 32'h0000CB2A, 1'b0);
    single(1'b0, 2'b00, 32'h09, 32'h0, 32'hCB2ACB29, 1'b0);

    single(1'b1, 2'b00, 32'h0F, 32'hAABBCCDD, 32'h0, 1'b0);
    single(1'b1, 2'b10, 32'h3D, 32'h01021034, 32'h0, 1'b0);
    single(1'b0, 2'b10, 32'h3D, 32'h0, 32'h00000034, 1'b0);
    single(1'b0, 2'b00, 32'h0F, 32'h0, 32'hAABB34DD, 1'b0);

    single(1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1);
    single(1'b1, 2'b01, 32'h200, 32'hDEADBEEF, 32'h0, 1'b1);
    single(1'b1, 2'b10, 32'h400, 32'hDEADBEEF, 32'h0, 1'b1);
    single(1'b1, 2'b11, 32'h000, 32'hDEADBEEF, 32'h0, 1'b1);
    single(1'b0, 2'b00, 32'h100, 32'h0, 32'h0, 1'b1);
    single(1'b0, 2'b01, 32'h200, 32'h0, 32'h0, 1'b1);
    single(1'b0, 2'b10, 32'h400, 32'h0, 32'h0, 1'b1);
    single(1'b0, 2'b11, 32'h000, 32'h0, 32'h0, 1'b1);
    single(1'b0, 2'b00, 32'h000, 32'h0, 32'h11223344, 1'b0);
    single(1'b0, 2'b01, 32'h1FF, 32'h0, 32'h00005566, 1'b0);
    single(1'b0, 2'b10, 32'h3FF, 32'h0, 32'h00000055, 1'b0);
    single(1'b0, 2'b10, 32'h3FC, 32'h0, 32'h00000088, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (3) @(negedge clk);
      issue(1'b1, 2'b00, 32'h90 + i, 32'hFBED4C97 + i, 32'h0, 1'b0);
    end
    finish_xfer();
    for (int j = 0; j < 32; j++) begin
      if (j > 0) repeat (3) @(negedge clk);
      w = 32'hFBED4C97 + j / 4;
      issue(1'b0, 2'b10, 32'h240 + j, 32'h0, (w >> (8 * (j % 4))) & 32'hFF, 1'b0);
    end
    finish_xfer();

    // Abandon a write by asserting rst just before its completion edge.
    single(1'b1, 2'b00, 32'h50, 32'h0BADF00D, 32'h0, 1'b0);
    bif.trnsfr = 1'b1; bif.wr = 1'b1; bif.dsel = 2'b00;
    bif.address = 32'h50; bif.data_in = 32'hFFFFFFFF;
    @(negedge clk) bif.trnsfr = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_psel",     {31'b0, dut.psel}, 32'h0);
    chk("midrst_data_out", bif.data_out,      32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    single(1'b0, 2'b00, 32'h50, 32'h0, 32'h0BADF00D, 1'b0);

    repeat (10) @(negedge clk);
    chk("sb_drain", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/apb2apb_bridge.md
Name: apb2apb_bridge

Overview:
- Converts a simple user transfer request (trnsfr/wr/dsel/address/data) into APB3 transactions.
- An internal APB master drives an internal APB bus to an APB slave wrapping a 256×32 word memory.
- Supports full-word, half-word and byte accesses, slave error on out-of-range access, and back-to-back (burst) transfers while trnsfr stays high.
- Sits between a simple local master and on-chip register/memory storage.

Parameters:
ADDR_WIDTH, 32, width of the user address and PADDR
DATA_WIDTH, 32, width of the data path and PWDATA/PRDATA
MEM_DEPTH, 256, number of 32-bit memory words

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
trnsfr  in  1  transfer request, sampled in IDLE and at transfer completion
wr  in  1  1=write, 0=read
dsel  in  2  access size: 00 FULLWORD, 01 HALFWORD, 10 BYTE, 11 reserved
address  in  ADDR_WIDTH  address in units of the selected size
data_in  in  DATA_WIDTH  write data, right-justified
data_out  out  DATA_WIDTH  read data, right-justified, zero-extended
slverr  out  1  one-cycle pulse when a transfer completes with PSLVERR
done  out  1  one-cycle pulse on every transfer completion

Behaviour:
- Reset values: master FSM=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PSTRB=0, data_out=0, slverr=0, done=0.
- Memory contents are not reset.
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when trnsfr=1. On that edge, latch address, wr, dsel and data_in into PADDR/PWRITE/size/PWDATA.
  - SETUP: PSEL=1, PENABLE=0. Always →ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0.
  - On PREADY=1: complete the transfer. Go to SETUP (re-latching the inputs) if trnsfr=1, else IDLE.
- Slave inserts exactly one wait state: PREADY=0 in the first ACCESS cycle, 1 in the second. Each transfer is therefore 3 cycles (SETUP, ACCESS, ACCESS). A burst with trnsfr held high issues one transfer every 3 cycles.
- Single transfer: with trnsfr sampled at edge 0, completion happens at edge 3. data_out, done and slverr update at edge 3.
- Address mapping (word index w, lane):
  - FULLWORD: w=addr; all 4 byte strobes.
  - HALFWORD: w=addr>>1; half addr[0]; strobes 0011 or 1100.
  - BYTE: w=addr>>2; lane addr[1:0]; one-hot strobe.
  - Little-endian lane order.
- Write: the low bits of data_in are replicated into the selected lane. Only strobed bytes are written, on the completion edge.
- Read: the selected lane is shifted down to bit 0 and zero-extended. data_out holds its value until the next read completes. Writes never change data_out.
- Slave error conditions:
  - FULLWORD addr ≥ 0x100.
  - HALFWORD addr ≥ 0x200.
  - BYTE addr ≥ 0x400.
  - Any dsel=11.
- On a slave error: PSLVERR=1 in the completing cycle, no memory write, read returns data_out=0, slverr pulses.
- trnsfr dropping mid-transfer does not abort the transfer; it finishes and the FSM returns to IDLE.
- Input changes outside the latch edges are ignored.
- rst asserted mid-transfer: the FSM returns to IDLE at the next edge and the transfer is abandoned with no memory write.

Decomposition:
- Package apb2apb_pkg holds:
  - the dsel_t enum (FULLWORD, HALFWORD, BYTE);
  - the master state enum;
  - the ADDR_WIDTH/DATA_WIDTH/MEM_DEPTH defaults;
  - the per-size range limits.
- One sub-module, apb2apb_slave_mem: the APB slave with the wait-state generator, range check, strobe and lane logic, and the 256×32 memory.
- The master FSM lives in the top level.

Test Plan:
- Reset: hold rst 5 cycles → PSEL=0, PENABLE=0, data_out=0, slverr=0, done=0.
- Fullword: write 0xF0..0xF9 with data 0x000A3210+i, then read the same addresses → data_out 0x000A3210+i. done pulses 3 cycles after each trnsfr sample.
- Halfword: write 0x12 with 0x510FCB29 and 0x13 with 0x510FCB2A → word 9 = 0xCB2ACB29. Reading 0x13 → 0x0000CB2A.
- Byte: write 0x3D with 0x01021034 → word 0x0F byte1 = 0x34, other bytes unchanged. Reading 0x3D → 0x00000034.
- Error: fullword 0x100, halfword 0x200, byte 0x400 write then read → slverr pulse each time, memory unchanged, read data_out=0.
- Burst: hold trnsfr and write fullword 0x90..0x97 with 0xFBED4C97+i, one transfer per 3 cycles. Then burst-read bytes 0x240..0x25F → 0x97, 0x4C, 0xED, 0xFB, 0x98, ... in order.
